// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and helpers for valid/ready pipeline stages.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } stage_state_t;

    localparam int unsigned PIPE_DEFAULT_DW = 32;

    // Total payload width of a stage carrying nf fields of dw bits each.
    function automatic int unsigned payload_width(input int unsigned dw, input int unsigned nf);
        return dw * nf;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: upstream and downstream valid/ready bus of one pipeline stage.
// The slave modport is the stage's own view; master is the surrounding pipeline.
interface pipe_stage_reg_if
    import pipe_pkg::*;
#(
    parameter int unsigned PW = payload_width(PIPE_DEFAULT_DW, 3)
) ();

    logic          valid_i;
    logic          ready_o;
    logic [PW-1:0] data_i;
    logic          valid_o;
    logic          ready_i;
    logic [PW-1:0] data_o;

    modport slave (
        input  valid_i,
        input  data_i,
        input  ready_i,
        output ready_o,
        output valid_o,
        output data_o
    );

    modport master (
        output valid_i,
        output data_i,
        output ready_i,
        input  ready_o,
        input  valid_o,
        input  data_o
    );

endinterface

// File: rtl/pipe_stage_reg_sat_counter.sv
// sat_counter: saturating up-counter, synchronous active-high reset, sticks at all-ones.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] r_count;

    // Count up on inc_i until all-ones, then hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc_i && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count_o = r_count;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic valid/ready pipeline stage register with flush and stall counter.
// Macro PIPE_STAGE_SKID_EN: adds a second (skid) entry so ready_o depends only on
// registered state; without it the stage is single-entry and ready_o follows ready_i.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = PIPE_DEFAULT_DW,
    parameter int unsigned NUM_FIELDS     = 3,
    parameter int unsigned CLEAR_ON_FLUSH = 0,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    pipe_stage_reg_if.slave      bus,
    output logic [CNT_WIDTH-1:0] stall_cnt_o
);

    localparam int unsigned PW = payload_width(DATA_WIDTH, NUM_FIELDS);

    stage_state_t  r_state;
    logic [PW-1:0] r_main;
`ifdef PIPE_STAGE_SKID_EN
    logic [PW-1:0] r_skid;
`endif
    logic          w_valid;
    logic          w_stall;

    // Stage occupancy: rst beats flush beats the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_main  <= '0;
`ifdef PIPE_STAGE_SKID_EN
            r_skid  <= '0;
`endif
        end else if (flush_i) begin
            r_state <= ST_EMPTY;
            if (CLEAR_ON_FLUSH != 0) begin
                r_main <= '0;
`ifdef PIPE_STAGE_SKID_EN
                r_skid <= '0;
`endif
            end
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (bus.valid_i) begin
                        r_main  <= bus.data_i;
                        r_state <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (bus.ready_i) begin
                        if (bus.valid_i) begin
                            r_main <= bus.data_i;
                        end else begin
                            r_state <= ST_EMPTY;
                        end
                    end
`ifdef PIPE_STAGE_SKID_EN
                    else if (bus.valid_i) begin
                        r_skid  <= bus.data_i;
                        r_state <= ST_SKID;
                    end
`endif
                end
`ifdef PIPE_STAGE_SKID_EN
                ST_SKID: begin
                    if (bus.ready_i) begin
                        r_main  <= r_skid;
                        r_state <= ST_FULL;
                    end
                end
`endif
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

    assign w_valid     = (r_state != ST_EMPTY);
    assign bus.valid_o = w_valid;
    assign bus.data_o  = r_main;

`ifdef PIPE_STAGE_SKID_EN
    assign bus.ready_o = (r_state != ST_SKID) && !rst;
`else
    assign bus.ready_o = (!w_valid || bus.ready_i) && !rst;
`endif

    assign w_stall = w_valid && !bus.ready_i;

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (w_stall),
        .count_o (stall_cnt_o)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: randomized scoreboard bench for pipe_stage_reg.
// Two DUTs share stimulus: one keeps payload on flush (4-bit counter), one clears it (16-bit).
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int unsigned DW  = 32;
    localparam int unsigned NF  = 3;
    localparam int unsigned PW  = DW * NF;
`ifdef PIPE_STAGE_SKID_EN
    localparam int          CAP = 2;
`else
    localparam int          CAP = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          flush_i;
    logic          valid_i;
    logic          ready_i;
    logic [PW-1:0] data_i;
    logic [3:0]    cnt0;
    logic [15:0]   cnt1;

    pipe_stage_reg_if #(.PW(PW)) if0 ();
    pipe_stage_reg_if #(.PW(PW)) if1 ();

    assign if0.valid_i = valid_i;
    assign if0.data_i  = data_i;
    assign if0.ready_i = ready_i;
    assign if1.valid_i = valid_i;
    assign if1.data_i  = data_i;
    assign if1.ready_i = ready_i;

    pipe_stage_reg #(
        .DATA_WIDTH(DW), .NUM_FIELDS(NF), .CLEAR_ON_FLUSH(0), .CNT_WIDTH(4)
    ) dut0 (
        .clk(clk), .rst(rst), .flush_i(flush_i), .bus(if0), .stall_cnt_o(cnt0)
    );

    pipe_stage_reg #(
        .DATA_WIDTH(DW), .NUM_FIELDS(NF), .CLEAR_ON_FLUSH(1), .CNT_WIDTH(16)
    ) dut1 (
        .clk(clk), .rst(rst), .flush_i(flush_i), .bus(if1), .stall_cnt_o(cnt1)
    );

    always #5 clk = ~clk;

    // Reference model: ordered list of transfers held by the stage, plus payload/counter shadows.
    logic [PW-1:0] q[$];
    int            occ = 0;
    logic [PW-1:0] main0 = '0;
    logic [PW-1:0] main1 = '0;
    int unsigned   cnt0_m = 0;
    int unsigned   cnt1_m = 0;
    int            total = 0;
    int            bad = 0;

    function automatic void check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [PW-1:0] rnd_payload();
        return {$urandom, $urandom, $urandom};
    endfunction

    // Driver: apply one cycle of inputs; record what the stage must later emit.
    task automatic drive(input logic v, input logic [PW-1:0] d, input logic rdy,
                         input logic fl, input logic r);
        @(posedge clk);
        #2;
        valid_i = v;
        data_i  = d;
        ready_i = rdy;
        flush_i = fl;
        rst     = r;
        #1;
        if (!r && !fl && v && if0.ready_o) q.push_back(d);
    endtask

    // Post-edge monitor: registered outputs against the model state.
    always @(posedge clk) begin
        #1;
        occ = q.size();
        if (occ > 0) begin
            main0 = q[0];
            main1 = q[0];
        end
        check("valid0", PW'(if0.valid_o), PW'(occ > 0));
        check("valid1", PW'(if1.valid_o), PW'(occ > 0));
        check("data0",  if0.data_o, main0);
        check("data1",  if1.data_o, main1);
        check("cnt0",   PW'(cnt0), PW'(cnt0_m));
        check("cnt1",   PW'(cnt1), PW'(cnt1_m));
    end

    // Mid-cycle monitor: ready_o, scoreboard pop on output transfer, then model update.
    always @(negedge clk) begin
        logic          exp_rdy;
        logic [PW-1:0] e;
`ifdef PIPE_STAGE_SKID_EN
        exp_rdy = !rst && (occ < CAP);
`else
        exp_rdy = !rst && ((occ == 0) || ready_i);
`endif
        check("ready0", PW'(if0.ready_o), PW'(exp_rdy));
        check("ready1", PW'(if1.ready_o), PW'(exp_rdy));
        if (if0.valid_o && ready_i) begin
            if (q.size() == 0) begin
                check("pop_empty", PW'(1), PW'(0));
            end else begin
                e = q.pop_front();
                check("out0", if0.data_o, e);
                check("out1", if1.data_o, e);
            end
        end
        if (rst) begin
            q.delete();
            main0  = '0;
            main1  = '0;
            cnt0_m = 0;
            cnt1_m = 0;
        end else begin
            if ((occ > 0) && !ready_i) begin
                if (cnt0_m < 15)    cnt0_m++;
                if (cnt1_m < 65535) cnt1_m++;
            end
            if (flush_i) begin
                q.delete();
                main1 = '0;
            end
        end
    end

    initial begin
        logic [PW-1:0] first;
        rst     = 1'b1;
        flush_i = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        data_i  = '0;
        first   = {32'h4, 32'h0, 32'h00500093};

        repeat (2) drive(1'b0, '0, 1'b0, 1'b0, 1'b1);

        // First fetch-to-decode transfer, then drain.
        drive(1'b1, first, 1'b1, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Back-to-back stream at full throughput.
        repeat (8) drive(1'b1, rnd_payload(), 1'b1, 1'b0, 1'b0);
        repeat (2) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Stall for 4 cycles while upstream keeps offering, then drain.
        drive(1'b1, rnd_payload(), 1'b1, 1'b0, 1'b0);
        repeat (4) drive(1'b1, rnd_payload(), 1'b0, 1'b0, 1'b0);
        repeat (4) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Flush with both entries occupied and an input on offer.
        drive(1'b1, rnd_payload(), 1'b1, 1'b0, 1'b0);
        repeat (2) drive(1'b1, rnd_payload(), 1'b0, 1'b0, 1'b0);
        drive(1'b1, rnd_payload(), 1'b0, 1'b1, 1'b0);
        repeat (2) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Long stall saturates the 4-bit counter; flush must not clear it.
        drive(1'b1, rnd_payload(), 1'b1, 1'b0, 1'b0);
        repeat (20) drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, rnd_payload(), 1'b0, 1'b1, 1'b0);
        repeat (2) drive(1'b0, '0, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a stream.
        repeat (3) drive(1'b1, rnd_payload(), 1'b1, 1'b0, 1'b0);
        drive(1'b1, rnd_payload(), 1'b1, 1'b0, 1'b1);
        repeat (3) drive(1'b1, rnd_payload(), 1'b1, 1'b0, 1'b0);

        // Random traffic with occasional flush and reset.
        repeat (1500) begin
            drive(1'($urandom_range(0, 9) < 7), rnd_payload(),
                  1'($urandom_range(0, 9) < 6),
                  1'($urandom_range(0, 15) == 0),
                  1'($urandom_range(0, 63) == 0));
        end

        repeat (4) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register replacing the per-stage fetch/decode register style with a generic valid/ready stage. It carries `NUM_FIELDS` packed words of `DATA_WIDTH` bits between any two pipeline stages, for example instruction, PC and PC+4 from fetch to decode. The stage supports back-pressure, flush and a saturating stall counter. An optional two-entry skid buffer registers the `ready_o` path so stall logic does not chain combinationally through the pipeline.

## Interface
- `DATA_WIDTH`, 32, width of one payload field.
- `NUM_FIELDS`, 3, number of payload fields; payload width `PW = DATA_WIDTH*NUM_FIELDS`.
- `CLEAR_ON_FLUSH`, 0, if 1 a flush also zeroes the payload registers.
- `CNT_WIDTH`, 16, width of the stall counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `flush_i`  in  1  discard all held and incoming transfers this cycle.
- `valid_i`  in  1  upstream has a transfer.
- `ready_o`  out  1  stage can accept a transfer.
- `data_i`  in  PW  upstream payload; field k is `[k*DATA_WIDTH +: DATA_WIDTH]`.
- `valid_o`  out  1  stage holds a transfer for downstream.
- `ready_i`  in  1  downstream accepts; replaces the old active-low-stall `en`.
- `data_o`  out  PW  held payload.
- `stall_cnt_o`  out  CNT_WIDTH  cycles with `valid_o && !ready_i`.

## Operation
- Transfers:
  - Input transfer: `valid_i && ready_o`.
  - Output transfer: `valid_o && ready_i`.
- Payload registers load only on an accepted transfer; otherwise they hold.
- `data_o` is meaningless while `valid_o` is 0.
- State machine, with `main` and `skid` payload registers:
  - `ST_EMPTY`
    - Input transfer: load `main`, go to `ST_FULL`.
  - `ST_FULL`
    - `valid_i && ready_i`: load `main`, stay in `ST_FULL`.
    - `!valid_i && ready_i`: go to `ST_EMPTY`.
    - `valid_i && !ready_i`, skid mode: load `skid`, go to `ST_SKID`.
    - Otherwise: hold.
  - `ST_SKID`
    - `ready_i`: `main <= skid`, go to `ST_FULL`.
    - No input is accepted in this state.
- Outputs:
  - `valid_o = (state != ST_EMPTY)`.
  - `data_o = main`.
- `ready_o`:
  - Skid mode: `(state != ST_SKID) && !rst`. This is registered-state only and independent of `ready_i`.
  - No-skid mode: `(!valid_o || ready_i) && !rst`.
- Priority order: `rst` > `flush_i` > handshake.
- Flush:
  - Next state is `ST_EMPTY`.
  - An input offered in the flush cycle is dropped, even though `ready_o` may read 1.
  - An output transfer in the flush cycle still completes downstream.
  - With `CLEAR_ON_FLUSH` = 1, `main` and `skid` go to 0; otherwise they hold.
- Stall counter:
  - Increments each cycle `valid_o && !ready_i`.
  - Saturates at `2^CNT_WIDTH-1`.
  - Cleared by `rst` only; `flush_i` does not clear it.

## Timing
- Reset values: `valid_o` = 0, `data_o` = 0, `skid` = 0, `stall_cnt_o` = 0, state `ST_EMPTY`.
- `ready_o` is 0 during the `rst` cycle and 1 in the first cycle after.
- Latency:
  - Input accepted at edge N appears on `data_o`/`valid_o` after edge N, i.e. one cycle.
  - An input that lands in `skid` appears one cycle after the downstream accepts `main`.
- Throughput is one transfer per cycle when `ready_i` is held high.
- Skid mode: `ready_o` deasserts the cycle after the first stalled accept. Exactly one extra transfer is absorbed.
- Simultaneous `flush_i` and `rst`: reset values win.
- Reset or flush mid-stall empties both entries in one cycle.
- Counter at maximum with a continued stall holds at all-ones and does not wrap.

## Configuration
- Macro: `PIPE_STAGE_SKID_EN`.
- Defined:
  - Skid register and `ST_SKID` state are present.
  - `ready_o` has no combinational path from `ready_i`.
  - Storage is 2 entries.
- Undefined:
  - Single-entry stage; `ST_SKID` is unreachable and `skid` is not instantiated.
  - `ready_o = (!valid_o || ready_i) && !rst`, which is combinational from `ready_i`.
  - Per-cycle behaviour at `valid_o`/`data_o` is identical whenever `ready_i` never drops while `valid_o` = 1.

## Structure
- Shared package `pipe_pkg`:
  - `typedef enum logic [1:0] stage_state_t {ST_EMPTY, ST_FULL, ST_SKID}`.
  - Localparam `PIPE_DEFAULT_DW` = 32.
- One sub-module: `sat_counter` (parameter `WIDTH`; ports `clk`, `rst`, `inc_i`, `count_o`), used for `stall_cnt_o` and reusable by other stages.

## Test plan
- Reset, then `valid_i` = 1, `data_i` = {32'h4, 32'h0, 32'h00500093}, `ready_i` = 1 → next cycle `valid_o` = 1 and `data_o` equals the input; `ready_o` = 1 throughout after reset.
- Stream of 8 transfers with `ready_i` = 1 → 8 outputs in consecutive cycles, in order, `stall_cnt_o` = 0.
- Skid mode: hold `ready_i` = 0 for 4 cycles while streaming → `ready_o` drops after 1 extra accept; `stall_cnt_o` = 4; on `ready_i` = 1 both held words drain in order with no loss or duplication.
- `flush_i` in `ST_SKID` with `valid_i` = 1 → next cycle `valid_o` = 0, state `ST_EMPTY`; the offered input never appears; `data_o` retained when `CLEAR_ON_FLUSH` = 0 and zero when 1.
- `CNT_WIDTH` = 4, `ready_i` = 0 with `valid_o` = 1 for 20 cycles → `stall_cnt_o` saturates at 15; a later flush leaves it at 15; `rst` clears it to 0.
- Mid-stream `rst` with `valid_i` = 1 → `ready_o` = 0 during reset; next cycle `valid_o` = 0, `data_o` = 0, `stall_cnt_o` = 0.
